adc_scan_sequencer: RTL and testbench
=====================================

Name: adc_scan_sequencer

Overview:
Sequences the 12-bit SPI ADC engine across up to NUM_CH input channels on each sample tick. For each enabled channel it issues a start and waits for the engine's done or a timeout. It averages 2^AVG_LOG2 conversions per channel and publishes the results. It sits between the clock prescaler / SPI state machine and the consumers (LED test, 7-segment display path), replacing free-running single-channel capture.

Parameters:
NUM_CH, 4, number of ADC channels scanned (2..8)
CH_W, 2, channel index width, equal to clog2(NUM_CH)
DATA_W, 12, ADC sample width
AVG_LOG2, 2, log2 of conversions averaged per channel (0 means no averaging)
TIMEOUT, 64, clk cycles to wait for spi_done before abandoning a conversion

Ports:
clk  in  1  system clock (prescaled SPI domain clock)
rst_n  in  1  asynchronous active-low reset
ena  in  1  block enable
sample_tick  in  1  one-cycle pulse that starts a scan
ch_mask  in  NUM_CH  channel enable mask, captured at scan start
spi_start  out  1  one-cycle conversion request to the SPI engine
spi_ch  out  CH_W  channel for the current request, stable from ISSUE until done or timeout
spi_done  in  1  one-cycle pulse when spi_data is valid (DATA_VALID)
spi_data  in  DATA_W  conversion result
result_valid  out  1  one-cycle pulse when an averaged result is published
result_ch  out  CH_W  channel of the published result
result_data  out  DATA_W  averaged result
rd_ch  in  CH_W  read-port channel select
rd_data  out  DATA_W  last published result for rd_ch (combinational read)
busy  out  1  high whenever state is not IDLE
scan_done  out  1  one-cycle pulse when a scan completes
timeout_err  out  1  sticky; set on any timeout
overrun_err  out  1  sticky; set when sample_tick arrives while busy
err_clr  in  1  clears both sticky flags (set has priority in the same cycle)

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs, the result registers, the accumulator, counters and flags go to 0.
- States: IDLE, ISSUE, WAIT, ACCUM, NEXT.
- IDLE: when sample_tick=1, ena=1 and ch_mask!=0:
  - latch ch_mask into mask_q
  - set ch_idx to the lowest set bit
  - clear the accumulator and the sample counter
  - go to ISSUE
- IDLE with a tick and ch_mask=0: ignored; no scan_done.
- ISSUE (1 cycle): spi_start=1, spi_ch=ch_idx, timer cleared, go to WAIT.
- WAIT:
  - spi_done=1: capture spi_data and go to ACCUM.
  - Otherwise, timer reaches TIMEOUT-1: set timeout_err, discard this channel's partial accumulation, no result_valid, go to NEXT.
  - spi_done on the same cycle as the timeout: done wins.
- ACCUM (1 cycle):
  - acc += sample. The accumulator is DATA_W+AVG_LOG2 bits wide, so it never overflows.
  - If sample count = 2^AVG_LOG2-1: result_data = acc>>AVG_LOG2 (truncating), result_ch=ch_idx, result_valid=1 this cycle, the result register for ch_idx is updated, go to NEXT.
  - Otherwise: increment the count and go to ISSUE on the same channel.
- NEXT (1 cycle): find the next set bit in mask_q strictly above ch_idx.
  - Found: ch_idx = that bit, clear acc/count, go to ISSUE.
  - None: scan_done=1, go to IDLE.
- Latency: the first spi_start occurs 1 cycle after the accepted tick. result_valid occurs 1 cycle after the final spi_done for the channel.
- A sample_tick while not IDLE sets overrun_err and is otherwise ignored; ticks are not queued.
- ena=0 mid-scan:
  - The in-flight conversion runs to done or timeout, then the block returns to IDLE.
  - No result is published and no scan_done is pulsed.
  - spi_start is never issued while ena=0.
- ch_mask changes mid-scan have no effect until the next scan.
- rd_data reads the result register array. rd_ch >= NUM_CH returns 0.
- Reset mid-transfer returns to IDLE immediately. The SPI engine is not aborted by this block.

Decomposition:
- Package adc_scan_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, ACCUM, NEXT)
  - default constants for NUM_CH, DATA_W, AVG_LOG2, TIMEOUT
  - the acc width function DATA_W+AVG_LOG2
- One sub-module is natural: next_ch_finder, a combinational priority encoder.
  - Inputs: mask and current index, plus a "from start" flag.
  - Outputs: next index and a found flag.
  - It is used for both the IDLE start and the NEXT step.

Test Plan:
- ch_mask=4'b0101, AVG_LOG2=2, model returns 100,102,104,106 on ch0 and 4000 on every ch2 conversion, tick once -> 8 spi_start pulses. result_valid ch0=103, then ch2=4000, then scan_done; rd_ch=2 gives 4000.
- Model never asserts spi_done on ch1, mask=4'b0010 -> spi_start once. After TIMEOUT cycles timeout_err=1, no result_valid, scan_done=1, busy drops; err_clr then clears the flag.
- sample_tick pulsed again 5 cycles into a scan -> overrun_err=1. The scan completes normally with the same number of spi_start pulses as without the extra tick.
- ch_mask=0 with tick -> busy stays 0, no spi_start, no scan_done.
- ena dropped during WAIT on ch0, model returns done 10 cycles later -> no result_valid, no scan_done, no further spi_start; state returns to IDLE.
- rst_n pulsed low during WAIT -> all outputs and the result registers read 0 immediately (asynchronously). The next tick starts a clean scan from the lowest mask bit.

Source files
------------

// File: rtl/adc_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_scan_pkg
//  Description : Shared definitions for the ADC scan sequencer: the default
//                parameter values, the FSM state encodings and a helper that
//                sizes the averaging accumulator.
//  Revision    : 1.0  initial release
// ============================================================================
package adc_scan_pkg;

  // Default configuration values
  localparam int c_DEF_NUM_CH   = 4;
  localparam int c_DEF_DATA_W   = 12;
  localparam int c_DEF_AVG_LOG2 = 2;
  localparam int c_DEF_TIMEOUT  = 64;

  // Sequencer states (explicit 3-bit encoding)
  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_ISSUE = 3'd1;
  localparam logic [2:0] c_ST_WAIT  = 3'd2;
  localparam logic [2:0] c_ST_ACCUM = 3'd3;
  localparam logic [2:0] c_ST_NEXT  = 3'd4;

  // The accumulator carries AVG_LOG2 extra bits so that summing
  // 2^AVG_LOG2 full-scale samples can never overflow.
  function automatic int acc_width(input int data_w, input int avg_log2);
    return data_w + avg_log2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/next_ch_finder.sv
`default_nettype none
// ============================================================================
//  Module      : next_ch_finder
//  Description : Combinational priority encoder. Returns the lowest set bit
//                of mask, restricted to bits strictly above cur_idx unless
//                from_start is set (then the whole mask is searched).
//  Ports       : mask       - channel enable mask
//                cur_idx    - current channel index
//                from_start - search from bit 0 instead of above cur_idx
//                next_idx   - index of the channel found (0 if none)
//                found      - a qualifying bit exists
//  Revision    : 1.0  initial release
// ============================================================================
module next_ch_finder #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur_idx,
  input  logic              from_start,
  output logic [CH_W-1:0]   next_idx,
  output logic              found
);

  // Scanning downwards lets the lowest qualifying bit overwrite any higher one.
  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(cur_idx)))) begin
        next_idx = CH_W'(i);
        found    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_scan_sequencer
//  Description : On each sample tick, walks the enabled ADC channels in
//                ascending order. It requests 2^AVG_LOG2 conversions per
//                channel from the SPI engine, averages them and publishes the
//                result. Each conversion is abandoned after TIMEOUT cycles
//                without spi_done.
//  Ports       : clk/rst_n          - clock, async active-low reset
//                ena, sample_tick   - enable and scan trigger
//                ch_mask            - channels to scan (latched per scan)
//                spi_start/spi_ch   - conversion request to SPI engine
//                spi_done/spi_data  - conversion result from SPI engine
//                result_*           - averaged-result publish strobe
//                rd_ch/rd_data      - combinational result read port
//                busy, scan_done    - status
//                timeout_err, overrun_err, err_clr - sticky error flags
//  Revision    : 1.0  initial release
// ============================================================================
module adc_scan_sequencer
  import adc_scan_pkg::*;
#(
  parameter int NUM_CH   = c_DEF_NUM_CH,
  parameter int CH_W     = $clog2(NUM_CH),
  parameter int DATA_W   = c_DEF_DATA_W,
  parameter int AVG_LOG2 = c_DEF_AVG_LOG2,
  parameter int TIMEOUT  = c_DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              sample_tick,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              spi_start,
  output logic [CH_W-1:0]   spi_ch,
  input  logic              spi_done,
  input  logic [DATA_W-1:0] spi_data,
  output logic              result_valid,
  output logic [CH_W-1:0]   result_ch,
  output logic [DATA_W-1:0] result_data,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              scan_done,
  output logic              timeout_err,
  output logic              overrun_err,
  input  logic              err_clr
);

  localparam int c_ACC_W = acc_width(DATA_W, AVG_LOG2);
  localparam int c_CNT_W = AVG_LOG2 + 1;
  localparam int c_TMR_W = $clog2(TIMEOUT) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);

  logic [2:0]         r_state;
  logic [NUM_CH-1:0]  r_mask;
  logic [CH_W-1:0]    r_ch_idx;
  logic [c_ACC_W-1:0] r_acc;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_TMR_W-1:0] r_timer;
  logic [DATA_W-1:0]  r_sample;
  logic               r_abort;
  logic               r_timeout_err;
  logic               r_overrun_err;
  logic [DATA_W-1:0]  r_result [NUM_CH];

  logic [NUM_CH-1:0]  w_find_mask;
  logic               w_from_start;
  logic [CH_W-1:0]    w_next_idx;
  logic               w_found;
  logic               w_abort;
  logic [c_ACC_W-1:0] w_acc_sum;
  logic [DATA_W-1:0]  w_avg;
  logic               w_last;
  logic               w_publish;
  logic               w_timeout;

  // One encoder serves both the scan start (full live mask from bit 0)
  // and the step to the next channel (latched mask, above current index).
  assign w_from_start = (r_state == c_ST_IDLE);
  assign w_find_mask  = w_from_start ? ch_mask : r_mask;

  next_ch_finder #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_next_ch_finder (
    .mask       (w_find_mask),
    .cur_idx    (r_ch_idx),
    .from_start (w_from_start),
    .next_idx   (w_next_idx),
    .found      (w_found)
  );

  // Once ena drops mid-scan the scan is abandoned even if ena returns
  // before the in-flight conversion finishes.
  assign w_abort   = r_abort | ~ena;
  assign w_acc_sum = r_acc + c_ACC_W'(r_sample);
  // Dropping the low AVG_LOG2 bits is the truncating divide.
  assign w_avg     = w_acc_sum[c_ACC_W-1:AVG_LOG2];
  assign w_last    = (r_cnt == c_CNT_LAST);
  assign w_publish = (r_state == c_ST_ACCUM) && w_last && !w_abort;
  assign w_timeout = (r_state == c_ST_WAIT) && !spi_done && (r_timer == c_TMR_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_ST_IDLE;
      r_mask   <= '0;
      r_ch_idx <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_timer  <= '0;
      r_sample <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (sample_tick && ena && w_found) begin
            r_mask   <= ch_mask;
            r_ch_idx <= w_next_idx;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= c_ST_ISSUE;
          end
        end
        c_ST_ISSUE: begin
          r_timer <= '0;
          r_state <= w_abort ? c_ST_IDLE : c_ST_WAIT;
        end
        c_ST_WAIT: begin
          if (spi_done) begin
            r_sample <= spi_data;
            r_state  <= w_abort ? c_ST_IDLE : c_ST_ACCUM;
          end else if (r_timer == c_TMR_LAST) begin
            // Partial accumulation is discarded when NEXT reloads acc/count.
            r_state <= w_abort ? c_ST_IDLE : c_ST_NEXT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        c_ST_ACCUM: begin
          r_acc <= w_acc_sum;
          if (w_abort) begin
            r_state <= c_ST_IDLE;
          end else if (w_last) begin
            r_state <= c_ST_NEXT;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= c_ST_ISSUE;
          end
        end
        c_ST_NEXT: begin
          if (w_abort) begin
            r_state <= c_ST_IDLE;
          end else if (w_found) begin
            r_ch_idx <= w_next_idx;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= c_ST_ISSUE;
          end else begin
            r_state <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_abort <= 1'b0;
    end else if (r_state == c_ST_IDLE) begin
      r_abort <= 1'b0;
    end else if (!ena) begin
      r_abort <= 1'b1;
    end
  end

  // Sticky error flags; a set in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (err_clr) begin
        r_timeout_err <= 1'b0;
      end
      if (sample_tick && (r_state != c_ST_IDLE)) begin
        r_overrun_err <= 1'b1;
      end else if (err_clr) begin
        r_overrun_err <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_result_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_result[g] <= '0;
      end else if (w_publish && (r_ch_idx == CH_W'(g))) begin
        r_result[g] <= w_avg;
      end
    end
  end

  // Outputs are state decodes so an async reset clears them at once.
  assign spi_start    = (r_state == c_ST_ISSUE) && !w_abort;
  assign spi_ch       = r_ch_idx;
  assign result_valid = w_publish;
  assign result_ch    = w_publish ? r_ch_idx : '0;
  assign result_data  = w_publish ? w_avg : '0;
  assign busy         = (r_state != c_ST_IDLE);
  assign scan_done    = (r_state == c_ST_NEXT) && !w_abort && !w_found;
  assign timeout_err  = r_timeout_err;
  assign overrun_err  = r_overrun_err;
  assign rd_data      = (int'(rd_ch) < NUM_CH) ? r_result[rd_ch] : '0;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_scan_sequencer
//  Description : Directed self-checking bench for adc_scan_sequencer with a
//                behavioural SPI engine model (ch1 never answers, ch0 returns
//                100,102,104,106 cyclically, other channels return 4000).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adc_scan_sequencer;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int DATA_W = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              sample_tick;
  logic [NUM_CH-1:0] ch_mask;
  logic              spi_start;
  logic [CH_W-1:0]   spi_ch;
  logic              spi_done;
  logic [DATA_W-1:0] spi_data;
  logic              result_valid;
  logic [CH_W-1:0]   result_ch;
  logic [DATA_W-1:0] result_data;
  logic [CH_W-1:0]   rd_ch;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              scan_done;
  logic              timeout_err;
  logic              overrun_err;
  logic              err_clr;

  int n_checks = 0;
  int n_errors = 0;
  int n_start  = 0;
  int n_scan   = 0;
  int res_ch[$];
  int res_data[$];
  int model_lat = 3;
  int ch0_cnt   = 0;

  always #5 clk = ~clk;

  adc_scan_sequencer u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .sample_tick  (sample_tick),
    .ch_mask      (ch_mask),
    .spi_start    (spi_start),
    .spi_ch       (spi_ch),
    .spi_done     (spi_done),
    .spi_data     (spi_data),
    .result_valid (result_valid),
    .result_ch    (result_ch),
    .result_data  (result_data),
    .rd_ch        (rd_ch),
    .rd_data      (rd_data),
    .busy         (busy),
    .scan_done    (scan_done),
    .timeout_err  (timeout_err),
    .overrun_err  (overrun_err),
    .err_clr      (err_clr)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // SPI engine model
  initial begin : p_spi_model
    int ch;
    int val;
    spi_done = 1'b0;
    spi_data = '0;
    forever begin
      @(negedge clk);
      if (spi_start) begin
        ch = int'(spi_ch);
        if (ch != 1) begin
          if (ch == 0) begin
            val = 100 + 2 * (ch0_cnt % 4);
            ch0_cnt++;
          end else begin
            val = 4000;
          end
          repeat (model_lat) @(posedge clk);
          #2 spi_done = 1'b1;
          spi_data = 12'(val);
          @(posedge clk);
          #2 spi_done = 1'b0;
        end
      end
    end
  end

  // Output monitor
  initial begin : p_monitor
    forever begin
      @(negedge clk);
      if (spi_start) n_start++;
      if (scan_done) n_scan++;
      if (result_valid) begin
        res_ch.push_back(int'(result_ch));
        res_data.push_back(int'(result_data));
      end
    end
  end

  initial begin : p_watchdog
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_tick();
    @(posedge clk);
    #2 sample_tick = 1'b1;
    @(posedge clk);
    #2 sample_tick = 1'b0;
  endtask

  task automatic wait_scan(input string tag, input int base, input int budget);
    int k = 0;
    while (n_scan == base && k < budget) begin
      @(posedge clk);
      k++;
    end
    #2;
    check_val(tag, n_scan - base, 1);
  endtask

  task automatic check_two_results(input string tag, input int base);
    check_val({tag, "_nres"}, res_ch.size() - base, 2);
    if (res_ch.size() >= base + 2) begin
      check_val({tag, "_ch_a"}, res_ch[base], 0);
      check_val({tag, "_data_a"}, res_data[base], 103);
      check_val({tag, "_ch_b"}, res_ch[base+1], 2);
      check_val({tag, "_data_b"}, res_data[base+1], 4000);
    end
  endtask

  initial begin : p_main
    int bs, br, bd;
    rst_n       = 1'b0;
    ena         = 1'b1;
    sample_tick = 1'b0;
    ch_mask     = '0;
    err_clr     = 1'b0;
    rd_ch       = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_spi_start", int'(spi_start), 0);
    check_val("rst_spi_ch", int'(spi_ch), 0);
    check_val("rst_result_valid", int'(result_valid), 0);
    check_val("rst_scan_done", int'(scan_done), 0);
    check_val("rst_timeout_err", int'(timeout_err), 0);
    check_val("rst_overrun_err", int'(overrun_err), 0);
    for (int c = 0; c < NUM_CH; c++) begin
      rd_ch = 2'(c);
      #1 check_val("rst_rd_data", int'(rd_data), 0);
    end

    // Two-channel averaged scan
    sync();
    ch_mask = 4'b0101;
    bs = n_start; br = res_ch.size(); bd = n_scan;
    pulse_tick();
    @(negedge clk);
    check_val("t1_first_start", int'(spi_start), 1);
    check_val("t1_first_ch", int'(spi_ch), 0);
    wait_scan("t1_scan_done", bd, 2000);
    check_val("t1_starts", n_start - bs, 8);
    check_two_results("t1", br);
    rd_ch = 2'd2;
    @(negedge clk);
    check_val("t1_rd_ch2", int'(rd_data), 4000);
    rd_ch = 2'd0;
    #1 check_val("t1_rd_ch0", int'(rd_data), 103);
    rd_ch = 2'd1;
    #1 check_val("t1_rd_ch1", int'(rd_data), 0);

    // Timeout on a silent channel, exact cycle of the timeout
    sync();
    ch_mask = 4'b0010;
    bs = n_start; br = res_ch.size(); bd = n_scan;
    pulse_tick();
    @(negedge clk);
    check_val("t2_start", int'(spi_start), 1);
    check_val("t2_ch", int'(spi_ch), 1);
    repeat (64) @(negedge clk);
    check_val("t2_err_before", int'(timeout_err), 0);
    check_val("t2_done_before", int'(scan_done), 0);
    @(negedge clk);
    check_val("t2_err_set", int'(timeout_err), 1);
    check_val("t2_scan_done", int'(scan_done), 1);
    @(negedge clk);
    check_val("t2_busy_drop", int'(busy), 0);
    sync();
    check_val("t2_starts", n_start - bs, 1);
    check_val("t2_nres", res_ch.size() - br, 0);
    check_val("t2_nscan", n_scan - bd, 1);
    err_clr = 1'b1;
    sync();
    err_clr = 1'b0;
    @(negedge clk);
    check_val("t2_err_clr", int'(timeout_err), 0);

    // Overrun tick mid-scan, coinciding with err_clr (set wins)
    sync();
    ch_mask = 4'b0101;
    bs = n_start; br = res_ch.size(); bd = n_scan;
    pulse_tick();
    repeat (4) @(posedge clk);
    #2 sample_tick = 1'b1;
    err_clr = 1'b1;
    @(posedge clk);
    #2 sample_tick = 1'b0;
    err_clr = 1'b0;
    @(negedge clk);
    check_val("t3_overrun_set", int'(overrun_err), 1);
    wait_scan("t3_scan_done", bd, 2000);
    check_val("t3_starts", n_start - bs, 8);
    check_two_results("t3", br);
    check_val("t3_overrun_sticky", int'(overrun_err), 1);
    err_clr = 1'b1;
    sync();
    err_clr = 1'b0;
    @(negedge clk);
    check_val("t3_overrun_clr", int'(overrun_err), 0);

    // Empty mask is ignored
    sync();
    ch_mask = 4'b0000;
    bs = n_start; bd = n_scan;
    pulse_tick();
    @(negedge clk);
    check_val("t4_busy", int'(busy), 0);
    check_val("t4_spi_start", int'(spi_start), 0);
    repeat (5) @(posedge clk);
    #2;
    check_val("t4_starts", n_start - bs, 0);
    check_val("t4_nscan", n_scan - bd, 0);

    // ena dropped while waiting for a slow conversion
    sync();
    model_lat = 10;
    ch_mask = 4'b0001;
    bs = n_start; br = res_ch.size(); bd = n_scan;
    pulse_tick();
    @(posedge clk);
    #2 ena = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check_val("t5_busy_inflight", int'(busy), 1);
    repeat (15) @(posedge clk);
    #2;
    check_val("t5_busy_idle", int'(busy), 0);
    check_val("t5_starts", n_start - bs, 1);
    check_val("t5_nres", res_ch.size() - br, 0);
    check_val("t5_nscan", n_scan - bd, 0);
    ena = 1'b1;
    model_lat = 3;

    // Asynchronous reset during WAIT, then a clean scan
    sync();
    ch_mask = 4'b0010;
    rd_ch = 2'd0;
    pulse_tick();
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_val("t6_busy", int'(busy), 0);
    check_val("t6_spi_ch", int'(spi_ch), 0);
    check_val("t6_rd_ch0", int'(rd_data), 0);
    rd_ch = 2'd2;
    #1 check_val("t6_rd_ch2", int'(rd_data), 0);
    sync();
    rst_n = 1'b1;
    sync();
    ch_mask = 4'b0101;
    br = res_ch.size(); bd = n_scan;
    pulse_tick();
    @(negedge clk);
    check_val("t6_restart", int'(spi_start), 1);
    check_val("t6_restart_ch", int'(spi_ch), 0);
    wait_scan("t6_scan_done", bd, 2000);
    check_two_results("t6", br);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
